// File: rtl/uart_txrx.sv
// uart_txrx
//   Full-duplex 8N1 UART for the sensor-side serial link. Bus-side controllers
//   pulse `transmit` to send a command byte and watch `received` /
//   `recv_error` for response bytes.
//
// Ports
//   clk              system clock, rising edge
//   rst_n            asynchronous reset, active-low
//   rx               serial input, idle high, asynchronous to clk
//   tx               serial output, idle high
//   transmit         one-cycle request to send tx_byte (only accepted when idle)
//   tx_byte[7:0]     byte to send, sampled on the transmit cycle
//   received         one-cycle pulse: rx_byte holds a new good byte
//   rx_byte[7:0]     last correctly received byte, held until the next one
//   recv_error       one-cycle pulse: stop bit sampled low (framing error)
//   is_receiving     high while the RX FSM is not idle
//   is_transmitting  high while a frame is being sent
//   dbg_pins[5:0]    {err_sticky, recv_error, received, is_transmitting, tx, rx_sync}
//
// Handshake: transmit is a request pulse with no ready/ack; it is honoured
// only when the TX FSM is idle (is_transmitting=0 on that cycle), otherwise
// it is dropped. received / recv_error are single-cycle valid strobes with no
// back-pressure; rx_byte stays stable until the next good byte.
module uart_txrx #(
  parameter int CLOCK_HZ = 7000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  input  logic       transmit,
  input  logic [7:0] tx_byte,
  output logic       received,
  output logic [7:0] rx_byte,
  output logic       recv_error,
  output logic       is_receiving,
  output logic       is_transmitting,
  output logic [5:0] dbg_pins
);

  localparam int BIT_CLKS = CLOCK_HZ / BAUD;
  localparam int CNT_W    = $clog2(BIT_CLKS);

  // Counters are reloaded with N-1 and the event fires on the cycle they hit 0,
  // so a reload of BIT_LAST gives exactly BIT_CLKS clocks per bit.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CLKS / 2 - 1);

  localparam logic [2:0] RX_IDLE    = 3'd0;
  localparam logic [2:0] RX_START   = 3'd1;
  localparam logic [2:0] RX_DATA    = 3'd2;
  localparam logic [2:0] RX_STOP    = 3'd3;
  localparam logic [2:0] RX_RECOVER = 3'd4;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  // ---------------------------------------------------------------------------
  // rx synchronizer; rx_prev is one more stage used only for edge detection.
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  wire rx_fall = rx_prev & ~rx_sync;

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  logic [2:0]       rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [3:0]       rx_idx;
  logic [7:0]       rx_shift;
  logic             err_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_byte    <= '0;
      received   <= 1'b0;
      recv_error <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      received   <= 1'b0;
      recv_error <= 1'b0;
      if (rx_state != RX_IDLE && rx_state != RX_RECOVER && rx_cnt != '0)
        rx_cnt <= rx_cnt - 1'b1;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_cnt   <= HALF_LAST;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            // Line back high at mid start bit: treat as noise, no pulse.
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_cnt   <= BIT_LAST;
              rx_idx   <= '0;
              rx_state <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};  // LSB arrives first
            rx_cnt   <= BIT_LAST;
            rx_idx   <= rx_idx + 4'd1;
            if (rx_idx == 4'd7)
              rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            if (rx_sync) begin
              rx_byte  <= rx_shift;
              received <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              recv_error <= 1'b1;
              err_sticky <= 1'b1;
              rx_state   <= RX_RECOVER;
            end
          end
        end
        RX_RECOVER: begin
          // A line held low (break) must not be mistaken for a new start bit.
          if (rx_sync)
            rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign is_receiving = (rx_state != RX_IDLE);

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  logic [1:0]       tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_idx;
  logic [7:0]       tx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      if (tx_state != TX_IDLE && tx_cnt != '0)
        tx_cnt <= tx_cnt - 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (transmit) begin
            tx_shift <= tx_byte;
            tx_cnt   <= BIT_LAST;
            tx       <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_idx   <= '0;
            tx_cnt   <= BIT_LAST;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LAST;
            if (tx_idx == 4'd7) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_idx   <= tx_idx + 4'd1;
            end
          end
        end
        TX_STOP: begin
          if (tx_cnt == '0)
            tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign is_transmitting = (tx_state != TX_IDLE);

  assign dbg_pins = {err_sticky, recv_error, received, is_transmitting, tx, rx_sync};

endmodule

// File: tb/tb_uart_txrx.sv
`timescale 1ns/1ps
module tb_uart_txrx;

  localparam int BIT = 7000000 / 9600;  // 729 clocks per bit

  // ---------------------------------------------------------------------------
  // clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       transmit = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       rx;
  logic       tx, received, recv_error, is_receiving, is_transmitting;
  logic [7:0] rx_byte;
  logic [5:0] dbg_pins;

  always #71 clk = ~clk;

  assign rx = loop_en ? tx : rx_drv;

  uart_txrx dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx              (rx),
    .tx              (tx),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .received        (received),
    .rx_byte         (rx_byte),
    .recv_error      (recv_error),
    .is_receiving    (is_receiving),
    .is_transmitting (is_transmitting),
    .dbg_pins        (dbg_pins)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // scoreboard: pulses captured away from the active edge
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int rcv_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int last_rcv_cyc = 0;
  logic [7:0] last_good = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (received) begin
      rcv_cnt++;
      last_rcv_cyc = cyc;
      got_q.push_back(rx_byte);
    end
    if (recv_error) err_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // drives start bit, 8 data bits LSB first, then stop_val for stop_bits bit times
  task automatic drive_rx_frame(input logic [7:0] b, input logic stop_val, input int stop_bits);
    rx_drv = 1'b0;
    repeat (BIT) tick;
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (BIT) tick;
    end
    rx_drv = stop_val;
    repeat (BIT * stop_bits) tick;
  endtask

  // ---------------------------------------------------------------------------
  // tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst_n = 1'b0; rx_drv = 1'b1; transmit = 1'b0;
    repeat (5) tick;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_checks++;
    if ({received, recv_error, is_receiving, is_transmitting} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {received, recv_error, is_receiving, is_transmitting});
    end
    n_checks++;
    if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte); end
    n_checks++;
    if (dbg_pins[5] !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b want 0", dbg_pins[5]); end
    rst_n = 1'b1;
    repeat (3) tick;
  endtask

  // Sends b; optionally fires a second request (0x3C) 100 clocks into the frame.
  task automatic test_tx_frame(input logic [7:0] b, input bit inject_busy);
    logic [9:0] exp_bits;
    int k;
    exp_bits = {1'b1, b, 1'b0};  // bit k of the line frame is exp_bits[k]
    tx_byte = b; transmit = 1'b1;
    tick;
    transmit = 1'b0;
    tx_byte = 8'($urandom_range(0, 255));  // must not affect the latched byte
    n_checks++;
    if (is_transmitting !== 1'b1) begin n_fail++; $display("FAIL tx_busy_rise: got %b want 1", is_transmitting); end
    n_checks++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL tx_start_bit: got %b want 0", tx); end
    for (int c = 1; c <= 10 * BIT + 1; c++) begin
      if (inject_busy && c == 100) begin tx_byte = 8'h3C; transmit = 1'b1; end
      tick;
      transmit = 1'b0;
      if (c >= BIT / 2 + 1 && (c - BIT / 2 - 1) % BIT == 0) begin
        k = (c - BIT / 2 - 1) / BIT;
        n_checks++;
        if (tx !== exp_bits[k]) begin
          n_fail++;
          $display("FAIL tx_bit%0d byte %h: got %b want %b", k, b, tx, exp_bits[k]);
        end
      end
      if (c == 10 * BIT - 1) begin
        n_checks++;
        if (is_transmitting !== 1'b1) begin n_fail++; $display("FAIL tx_busy_end-1: got %b want 1", is_transmitting); end
      end
      if (c == 10 * BIT) begin
        n_checks++;
        if (is_transmitting !== 1'b0) begin n_fail++; $display("FAIL tx_busy_fall: got %b want 0", is_transmitting); end
      end
    end
    n_checks++;
    if ({is_transmitting, tx} !== 2'b01) begin
      n_fail++;
      $display("FAIL tx_idle_after: got busy/tx %b want 01", {is_transmitting, tx});
    end
  endtask

  task automatic test_rx_good(input logic [7:0] b);
    int r0, e0, s0, base;
    r0 = rcv_cnt; e0 = err_cnt; s0 = cyc; base = got_q.size();
    drive_rx_frame(b, 1'b1, 1);
    repeat (50) tick;
    n_checks++;
    if (rcv_cnt - r0 !== 1) begin n_fail++; $display("FAIL rx_pulse_count %h: got %0d want 1", b, rcv_cnt - r0); end
    n_checks++;
    if (rx_byte !== b) begin n_fail++; $display("FAIL rx_byte %h: got %h want %h", b, rx_byte, b); end
    n_checks++;
    if (got_q.size() > base && got_q[base] !== b) begin
      n_fail++; $display("FAIL rx_pulse_data %h: got %h want %h", b, got_q[base], b);
    end
    n_checks++;
    if (err_cnt !== e0) begin n_fail++; $display("FAIL rx_no_error %h: got %0d want 0", b, err_cnt - e0); end
    // stop-bit centre is 9.5 bit times after the start edge, plus synchronizer delay
    n_checks++;
    if (last_rcv_cyc - s0 < 9 * BIT + 300 || last_rcv_cyc - s0 > 9 * BIT + 450) begin
      n_fail++;
      $display("FAIL rx_pulse_time %h: got %0d clks want about %0d", b, last_rcv_cyc - s0, 9 * BIT + BIT / 2);
    end
    last_good = b;
  endtask

  task automatic test_framing;
    int r0, e0;
    r0 = rcv_cnt; e0 = err_cnt;
    drive_rx_frame(8'hFE, 1'b0, 3);
    n_checks++;
    if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL frame_err_count: got %0d want 1", err_cnt - e0); end
    n_checks++;
    if (is_receiving !== 1'b1) begin n_fail++; $display("FAIL frame_hold_low: got is_receiving %b want 1", is_receiving); end
    rx_drv = 1'b1;
    repeat (20) tick;
    n_checks++;
    if (is_receiving !== 1'b0) begin n_fail++; $display("FAIL frame_recover: got is_receiving %b want 0", is_receiving); end
    n_checks++;
    if (rcv_cnt !== r0) begin n_fail++; $display("FAIL frame_no_received: got %0d want 0", rcv_cnt - r0); end
    n_checks++;
    if (rx_byte !== last_good) begin n_fail++; $display("FAIL frame_rx_byte_kept: got %h want %h", rx_byte, last_good); end
    n_checks++;
    if (dbg_pins[5] !== 1'b1) begin n_fail++; $display("FAIL frame_sticky: got %b want 1", dbg_pins[5]); end
  endtask

  task automatic test_reset_midframe;
    tx_byte = 8'h00; transmit = 1'b1;
    tick;
    transmit = 1'b0;
    repeat (1000) tick;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx, is_transmitting} !== 2'b10) begin
      n_fail++; $display("FAIL midframe_reset: got tx/busy %b want 10", {tx, is_transmitting});
    end
    n_checks++;
    if ({dbg_pins[5], rx_byte} !== 9'h000) begin
      n_fail++; $display("FAIL midframe_reset_state: got sticky/rx_byte %h want 000", {dbg_pins[5], rx_byte});
    end
    tick;
    rst_n = 1'b1;
    last_good = 8'h00;
    repeat (800) tick;
    n_checks++;
    if ({tx, is_transmitting} !== 2'b10) begin
      n_fail++; $display("FAIL midframe_no_resume: got tx/busy %b want 10", {tx, is_transmitting});
    end
  endtask

  task automatic test_glitch;
    int r0, e0, fall_at;
    bit seen_high;
    r0 = rcv_cnt; e0 = err_cnt; fall_at = -1; seen_high = 1'b0;
    rx_drv = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      if (c == 200) rx_drv = 1'b1;
      tick;
      if (is_receiving) seen_high = 1'b1;
      if (seen_high && !is_receiving && fall_at < 0) fall_at = c;
    end
    n_checks++;
    if (fall_at < 340 || fall_at > 400) begin
      n_fail++; $display("FAIL glitch_fall_time: got %0d want about 367", fall_at);
    end
    n_checks++;
    if ({rcv_cnt - r0, err_cnt - e0} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL glitch_no_pulse: got rcv %0d err %0d want 0 0", rcv_cnt - r0, err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back_loopback;
    logic [7:0] bytes [7];
    int base, r0, e0, guard;
    bytes = '{8'hFE, 8'h44, 8'h00, 8'h08, 8'h02, 8'h9F, 8'h25};
    base = got_q.size(); r0 = rcv_cnt; e0 = err_cnt;
    exp_q.delete();
    loop_en = 1'b1;
    tick;
    for (int i = 0; i < 7; i++) begin
      guard = 0;
      while (is_transmitting && guard < 8000) begin tick; guard++; end
      n_checks++;
      if (guard >= 8000) begin n_fail++; $display("FAIL loop_wait_idle %0d: got busy want idle", i); end
      tx_byte = bytes[i]; transmit = 1'b1;
      tick;
      transmit = 1'b0;
      exp_q.push_back(bytes[i]);
      n_checks++;
      if (is_transmitting !== 1'b1) begin n_fail++; $display("FAIL loop_accept %0d: got busy %b want 1", i, is_transmitting); end
    end
    guard = 0;
    while (rcv_cnt - r0 < 7 && guard < 9000) begin tick; guard++; end
    repeat (20) tick;
    n_checks++;
    if (rcv_cnt - r0 !== 7) begin n_fail++; $display("FAIL loop_count: got %0d want 7", rcv_cnt - r0); end
    for (int i = 0; i < 7; i++) begin
      if (base + i < got_q.size()) begin
        n_checks++;
        if (got_q[base + i] !== exp_q[i]) begin
          n_fail++; $display("FAIL loop_byte%0d: got %h want %h", i, got_q[base + i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (err_cnt !== e0) begin n_fail++; $display("FAIL loop_no_error: got %0d want 0", err_cnt - e0); end
    loop_en = 1'b0;
  endtask

  initial begin
    test_reset;
    test_tx_frame(8'hA5, 1'b1);
    test_rx_good(8'h44);
    test_rx_good(8'($urandom_range(0, 255)));
    test_framing;
    test_reset_midframe;
    test_glitch;
    test_back_to_back_loopback;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
